// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the unified memory responder.
// Holds the responder state encoding, data/byte-enable widths and the
// default geometry used by unified_mem_resp and mem_array.
package mem_pkg;

    localparam int WORD_W          = 32;
    localparam int BE_W            = 4;
    localparam int DEPTH_WORDS_DEF = 1024;
    localparam int LAT_DEF         = 2;

    // IDLE accepts a request, WAIT burns the access latency, RESP presents it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// mem_array: single-port synchronous word RAM with per-byte write enables.
// A read captures the addressed word into rdata on the enabled edge; a
// write updates only the enabled byte lanes and leaves rdata untouched.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Storage and read register: byte-lane write or full-word read per enabled edge.
    // NOTE: the array has no reset on purpose -- contents must survive rst and a
    // reset branch would turn the RAM into a huge bank of resettable flops.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int lane = 0; lane < BE_W; lane++) begin
                    if (be[lane]) begin
                        mem_q[idx][8*lane +: 8] <= wdata[8*lane +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule : mem_array

// File: rtl/unified_mem_resp.sv
// unified_mem_resp: valid/ready memory responder with fixed access latency.
// A request accepted in IDLE is held in WAIT for LAT-1 cycles, committed
// to mem_array on the edge entering RESP, and presented until rsp_ready.
// Optional build macro MEM_MISALIGN_TRAP_EN: nonzero req_addr[1:0] faults.
module unified_mem_resp
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int LAT         = LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LAT > 2) ? $clog2(LAT - 1) : 1;
    // WAIT lasts LAT-1 cycles: counts CNT_LOAD down to zero inclusive.
    localparam logic [CNT_W-1:0] CNT_LOAD = (LAT > 1) ? CNT_W'(LAT - 2) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lat_we_q, lat_we_d;
    logic [WORD_W-1:0] lat_addr_q, lat_addr_d;
    logic [WORD_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [BE_W-1:0]   lat_be_q, lat_be_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rd_ok_q, rd_ok_d;

    logic              acc_we;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_err;
    logic              commit;
    logic [WORD_W-1:0] ram_rdata;

    // Select the access being committed: live request when LAT = 1, else the latched one.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_we    = lat_we_q;
        acc_addr  = lat_addr_q;
        acc_wdata = lat_wdata_q;
        acc_be    = lat_be_q;
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
        commit  = ((state_q == IDLE) && req_valid && (LAT == 1)) ||
                  ((state_q == WAIT) && (cnt_q == '0));
        acc_err = |acc_addr[WORD_W-1:IDX_W+2];
`ifdef MEM_MISALIGN_TRAP_EN
        acc_err = acc_err | (|acc_addr[1:0]);
`endif
    end

`ifndef MEM_MISALIGN_TRAP_EN
    // Byte offset within the word is ignored when misalignment is not trapped.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^acc_addr[1:0];
`endif

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .en    (commit && !acc_err),
        .we    (acc_we),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (ram_rdata)
    );

    // Next-state, latency counter, request capture and response flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_be_d    = lat_be_q;
        rsp_err_d   = rsp_err_q;
        rd_ok_d     = rd_ok_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lat_we_d    = req_we;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    lat_be_d    = req_be;
                    cnt_d       = CNT_LOAD;
                    state_d     = (LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            rsp_err_d = acc_err;
            rd_ok_d   = !acc_err && !acc_we;
        end else if ((state_q == RESP) && rsp_ready) begin
            rsp_err_d = 1'b0;
            rd_ok_d   = 1'b0;
        end
    end

    // State and response registers; reset aborts any access in flight.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= '0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_be_q    <= lat_be_d;
            rsp_err_q   <= rsp_err_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_err_q;
    // The RAM read register is untouched while in RESP, so gating keeps data stable.
    assign rsp_rdata = rd_ok_q ? ram_rdata : '0;

endmodule : unified_mem_resp
